lvds_link_sequencer: RTL

Bring-up and supervision controller for the LVDS PRBS loopback datapath, clocked in the RX slow-clock domain. It pulses the TX/RX PLL resets, waits for lock and settling, releases and starts the frame aligner, qualifies the PRBS checker status, and declares the link up. On loss of lock, loss of alignment or a sustained PRBS error run it retrains automatically, up to a bounded number of attempts. It also keeps diagnostic counters for the LED/debug logic.

---
 rtl/lvds_link_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lvds_link_sequencer.sv
// lvds_link_sequencer: bring-up and supervision FSM for the LVDS PRBS loopback link.
// Ports: rx_slowclk/rst; PLL, aligner and PRBS status in; retrain request in;
//   PLL/aligner/checker resets and aligner start out; link_up, link_fail, state;
//   retry_cnt, drop_cnt and err_cnt diagnostic counters.
module lvds_link_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 16'hFFFF,
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned ALIGN_TIMEOUT  = 16'hFFFF,
   parameter int unsigned PASS_CYCLES    = 1024,
   parameter int unsigned VERIFY_TIMEOUT = 16'hFFFF,
   parameter int unsigned ERR_RUN        = 16,
   parameter int unsigned MAX_RETRY      = 7
) (
   input  logic        rx_slowclk,
   input  logic        rst,
   input  logic        txpll_locked,
   input  logic        rxpll_locked,
   input  logic        fa_lock,
   input  logic        prbs_stat,
   input  logic        retrain,
   output logic        pll_rstn,
   output logic        fa_rstn,
   output logic        fa_start,
   output logic        chk_rstn,
   output logic        link_up,
   output logic        link_fail,
   output logic [2:0]  state,
   output logic [7:0]  retry_cnt,
   output logic [7:0]  drop_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_ALIGN     = 3'd3,
      S_VERIFY    = 3'd4,
      S_LINK_UP   = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   localparam logic [15:0] PLL_LAST    = 16'(PLL_RST_CYCLES - 1);
   localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] ALIGN_LAST  = 16'(ALIGN_TIMEOUT - 1);
   localparam logic [15:0] PASS_LAST   = 16'(PASS_CYCLES - 1);
   localparam logic [15:0] VERIFY_LAST = 16'(VERIFY_TIMEOUT - 1);
   localparam logic [15:0] RUN_LAST    = 16'(ERR_RUN - 1);
   localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRY);

   state_t      cur;
   state_t      nxt;
   logic [15:0] timer;
   logic [15:0] pass_cnt;
   logic [15:0] run_cnt;
   logic        locks;
   logic        fault;
   logic        drop_ev;
   logic        pass_ok;
   logic        timer_clr;
   logic [7:0]  retry_inc;

   assign locks     = txpll_locked & rxpll_locked;
   assign retry_inc = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;
   assign timer_clr = retrain | (nxt != cur);
   assign state     = cur;

   always_comb begin
      nxt     = cur;
      fault   = 1'b0;
      drop_ev = 1'b0;
      pass_ok = 1'b0;
      unique case (cur)
         S_RESET_PLL: begin
            if (timer == PLL_LAST) nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (locks) nxt = S_SETTLE;
            else if (timer == LOCK_LAST) fault = 1'b1;
         end
         S_SETTLE: begin
            if (!locks) fault = 1'b1;
            else if (timer == SETTLE_LAST) nxt = S_ALIGN;
         end
         S_ALIGN: begin
            if (!locks) fault = 1'b1;
            else if (fa_lock) nxt = S_VERIFY;
            else if (timer == ALIGN_LAST) fault = 1'b1;
         end
         S_VERIFY: begin
            if (!locks || !fa_lock) begin
               fault = 1'b1;
            end else if (prbs_stat && pass_cnt == PASS_LAST) begin
               nxt     = S_LINK_UP;
               pass_ok = 1'b1;
            end else if (timer == VERIFY_LAST) begin
               fault = 1'b1;
            end
         end
         S_LINK_UP: begin
            // several coincident causes still count as one drop
            if (!locks || !fa_lock ||
                (!prbs_stat && run_cnt == RUN_LAST)) begin
               fault   = 1'b1;
               drop_ev = 1'b1;
            end
         end
         S_FAIL: begin
            nxt = S_FAIL;
         end
         default: begin
            nxt = S_RESET_PLL;
         end
      endcase
      if (fault) begin
         nxt = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
      end
      if (retrain) begin
         nxt     = S_RESET_PLL;
         fault   = 1'b0;
         drop_ev = 1'b0;
         pass_ok = 1'b0;
      end
   end

   always_ff @(posedge rx_slowclk or posedge rst) begin
      if (rst) begin
         cur       <= S_RESET_PLL;
         timer     <= '0;
         pass_cnt  <= '0;
         run_cnt   <= '0;
         retry_cnt <= '0;
         drop_cnt  <= '0;
         err_cnt   <= '0;
         pll_rstn  <= 1'b0;
         fa_rstn   <= 1'b0;
         fa_start  <= 1'b0;
         chk_rstn  <= 1'b0;
         link_up   <= 1'b0;
         link_fail <= 1'b0;
      end else begin
         cur   <= nxt;
         timer <= timer_clr ? 16'd0 : timer + 16'd1;

         if (timer_clr || cur != S_VERIFY || !prbs_stat) pass_cnt <= '0;
         else pass_cnt <= pass_cnt + 16'd1;

         if (timer_clr || cur != S_LINK_UP || prbs_stat) run_cnt <= '0;
         else run_cnt <= run_cnt + 16'd1;

         if (retrain || pass_ok) retry_cnt <= '0;
         else if (fault) retry_cnt <= retry_inc;

         if (retrain) drop_cnt <= '0;
         else if (drop_ev && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

         if (retrain) err_cnt <= '0;
         else if (cur == S_LINK_UP && !prbs_stat && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;

         // decoded from the next state so they track state exactly
         pll_rstn  <= !(nxt == S_RESET_PLL || nxt == S_FAIL);
         fa_rstn   <= (nxt == S_ALIGN || nxt == S_VERIFY || nxt == S_LINK_UP);
         fa_start  <= (nxt == S_ALIGN || nxt == S_VERIFY || nxt == S_LINK_UP);
         chk_rstn  <= (nxt == S_VERIFY || nxt == S_LINK_UP);
         link_up   <= (nxt == S_LINK_UP);
         link_fail <= (nxt == S_FAIL);
      end
   end

endmodule
